// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Bus widths, hold levels, fetch entry layout and FSM encoding.
package ifu_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;
  localparam int unsigned HoldFlagW = 3;

  localparam logic [HoldFlagW-1:0] HoldNone = 3'b000;
  localparam logic [HoldFlagW-1:0] HoldPc   = 3'b001;
  localparam logic [HoldFlagW-1:0] HoldIf   = 3'b010;
  localparam logic [HoldFlagW-1:0] HoldId   = 3'b011;

  localparam int unsigned          IfuMaxOutstanding = 2;
  localparam logic [InstAddrW-1:0] BootAddr          = 32'h0000_0000;

  typedef struct packed {
    logic [InstW-1:0]     inst;
    logic [InstAddrW-1:0] addr;
    logic                 next_type;
  } fetch_entry_t;

  typedef struct packed {
    logic [InstAddrW-1:0] addr;
    logic                 next_type;
  } fetch_tag_t;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold
  } ifu_state_e;

  function automatic logic [InstAddrW-1:0] word_align(input logic [InstAddrW-1:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Pipelined req/gnt request phase with in-order rvalid responses.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                 req;
  logic [InstAddrW-1:0] addr;
  logic                 gnt;
  logic                 rvalid;
  logic [InstW-1:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous FIFO holding returned fetch entries.
// Optional fall-through; flush_i empties it in one cycle and overrides push/pop.
module ifu_fetch_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 2,
  parameter type         dtype        = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  dtype                         data_i,
  input  logic                         pop_i,
  output dtype                         data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en, rd_en;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_en   = push_i && (cnt_q != Full);
    rd_en   = pop_i && (cnt_q != '0);
    data_o  = mem_q[rptr_q];
    empty_o = (cnt_q == '0);
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o  = data_i;
      empty_o = 1'b0;
      // Bypassed entry consumed directly; never stored.
      if (pop_i) wr_en = 1'b0;
    end
    if (flush_i) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    wptr_d = wr_en ? next_ptr(wptr_q) : wptr_q;
    rptr_d = rd_en ? next_ptr(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CntW'(wr_en) - CntW'(rd_en);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues pipelined bus requests and queues
// responses for IF/ID; on a redirect it flushes the queue and drops stale responses.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [InstAddrW-1:0] BOOT_ADDR       = BootAddr,
  parameter int unsigned          MAX_OUTSTANDING = IfuMaxOutstanding
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jump_flag_i,
  input  logic [InstAddrW-1:0] jump_addr_i,
  input  logic [HoldFlagW-1:0] hold_flag_i,
  ifu_fetch_if.master          bus_if,
  input  logic                 instr_req_i,
  output logic                 instr_ready_o,
  output logic [InstW-1:0]     inst_o,
  output logic [InstAddrW-1:0] inst_addr_o,
  output logic                 inst_addr_next_type_o
);

  localparam int unsigned       CntW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned       PtrW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PtrW-1:0]   LastPtr  = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW+1:0]   MaxInUse = (CntW + 2)'(MAX_OUTSTANDING);

  ifu_state_e           state_q, state_d;
  logic [InstAddrW-1:0] pc_q, pc_d;
  logic                 first_q, first_d;
  logic [CntW-1:0]      outst_q, outst_d;
  logic [CntW-1:0]      discard_q, discard_d;
  logic [PtrW-1:0]      tag_wptr_q, tag_wptr_d;
  logic [PtrW-1:0]      tag_rptr_q, tag_rptr_d;
  fetch_tag_t           tag_q [MAX_OUTSTANDING];

  logic                 jump, hold, grant, resp_keep, resp_pop;
  logic [CntW+1:0]      in_use;
  logic                 q_empty;
  logic [CntW-1:0]      q_cnt;
  fetch_entry_t         q_in, q_out;

  function automatic logic [PtrW-1:0] tag_next(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign jump     = jump_flag_i && (state_q != StBoot);
  assign hold     = (hold_flag_i >= HoldPc);
  // Discards are counted on top of outstanding so a response always has a queue slot.
  assign in_use   = {2'b00, outst_q} + {2'b00, discard_q} + {2'b00, q_cnt};

  assign bus_if.req  = (state_q == StRun) && !jump_flag_i && (in_use < MaxInUse);
  assign bus_if.addr = pc_q;

  assign grant     = bus_if.req && bus_if.gnt;
  assign resp_keep = bus_if.rvalid && !jump && (discard_q == '0);
  assign resp_pop  = instr_ready_o && instr_req_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      // An ungranted request is kept on the bus until accepted before holding.
      StRun:  if (hold && !(bus_if.req && !bus_if.gnt)) state_d = StHold;
      StHold: if (!hold) state_d = StRun;
      default: state_d = StBoot;
    endcase

    pc_d    = pc_q;
    first_d = first_q;
    if (jump) begin
      pc_d    = word_align(jump_addr_i);
      first_d = 1'b1;
    end else if (grant) begin
      pc_d    = pc_q + 32'd4;
      first_d = 1'b0;
    end

    outst_d = outst_q + CntW'(grant) - CntW'(bus_if.rvalid);

    if (jump) begin
      discard_d = outst_q - CntW'(bus_if.rvalid);
    end else if (bus_if.rvalid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end else begin
      discard_d = discard_q;
    end

    // Tags of stale requests are flushed at once; their responses never pop a tag.
    tag_wptr_d = grant ? tag_next(tag_wptr_q) : tag_wptr_q;
    if (jump) begin
      tag_rptr_d = tag_wptr_q;
    end else if (resp_keep) begin
      tag_rptr_d = tag_next(tag_rptr_q);
    end else begin
      tag_rptr_d = tag_rptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StBoot;
      pc_q       <= BOOT_ADDR;
      first_q    <= 1'b1;
      outst_q    <= '0;
      discard_q  <= '0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      first_q    <= first_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_q[tag_wptr_q] <= '{addr: pc_q, next_type: first_q};
    end
  end

  assign q_in = '{
    inst:      bus_if.rdata,
    addr:      tag_q[tag_rptr_q].addr,
    next_type: tag_q[tag_rptr_q].next_type
  };

  ifu_fetch_fifo #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MAX_OUTSTANDING),
    .dtype        (fetch_entry_t)
  ) u_resp_q (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (jump),
    .push_i  (resp_keep),
    .data_i  (q_in),
    .pop_i   (resp_pop),
    .data_o  (q_out),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  assign instr_ready_o         = !q_empty;
  assign inst_o                = instr_ready_o ? q_out.inst : '0;
  assign inst_addr_o           = instr_ready_o ? q_out.addr : '0;
  assign inst_addr_next_type_o = instr_ready_o && q_out.next_type;

endmodule
